// File: rtl/hazard_forward_unit.sv
// Operand bypass selection and load-use stall control for a five-stage pipeline.
// Forwarding is purely combinational; load-use stalls run through a small IDLE/HOLD machine.
module hazard_forward_unit #(
  parameter int NUM_SRC    = 2,
  parameter int AW         = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [NUM_SRC*AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]    id_src_used,
  input  logic [AW-1:0]         ex_dst,
  input  logic [AW-1:0]         mem_dst,
  input  logic [AW-1:0]         wb_dst,
  input  logic                  ex_wen,
  input  logic                  mem_wen,
  input  logic                  wb_wen,
  input  logic                  ex_is_load,
  input  logic                  flush,
  input  logic                  clr_cnt,
  output logic [NUM_SRC*2-1:0]  fwd_sel,
  output logic                  stall,
  output logic                  bubble,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic       MULTI_STALL = (LOAD_STALL > 1);
  localparam logic [1:0] REM_INIT    = 2'(LOAD_STALL - 1);

  logic [NUM_SRC-1:0] ex_hit;
  logic [NUM_SRC-1:0] mem_hit;
  logic [NUM_SRC-1:0] wb_hit;
  logic               hazard;

  state_t     state, state_next;
  logic [1:0] rem, rem_next;
  logic       stall_int;

  // Register 0 is hard-wired zero, so a write to it never produces a match.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [AW-1:0] src;
    assign src        = id_src[g*AW +: AW];
    assign ex_hit[g]  = ex_wen  && (ex_dst  != '0) && (ex_dst  == src);
    assign mem_hit[g] = mem_wen && (mem_dst != '0) && (mem_dst == src);
    assign wb_hit[g]  = wb_wen  && (wb_dst  != '0) && (wb_dst  == src);

    assign fwd_sel[2*g +: 2] = !(rst_n && id_src_used[g]) ? 2'b00 :
                               ex_hit[g]                  ? 2'b11 :
                               mem_hit[g]                 ? 2'b10 :
                               wb_hit[g]                  ? 2'b01 : 2'b00;
  end

  assign hazard = id_valid && !flush && ex_is_load && |(ex_hit & id_src_used);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next = state;
    rem_next   = rem;
    stall_int  = 1'b0;
    unique case (state)
      IDLE: begin
        stall_int = hazard;
        if (hazard && MULTI_STALL) begin
          state_next = HOLD;
          rem_next   = REM_INIT;
        end
      end
      HOLD: begin
        if (flush) begin
          state_next = IDLE;
          rem_next   = 2'd0;
        end else begin
          stall_int = 1'b1;
          rem_next  = rem - 2'd1;
          if (rem <= 2'd1) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        rem_next   = 2'd0;
      end
    endcase
  end

  // Outputs are held inactive for as long as reset is asserted, not just after an edge.
  assign stall  = stall_int && rst_n;
  assign bubble = stall;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state <= IDLE;
      rem   <= 2'd0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench: two configurations share one stimulus stream; a cycle-level model
// written from the behavioural rules pushes expectations that a monitor pops and compares.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, ex_wen, mem_wen, wb_wen, ex_is_load, flush, clr_cnt;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic [4:0]  ex_dst, mem_dst, wb_dst;

  logic [3:0]  fwd_a, fwd_b;
  logic        stall_a, bubble_a, stall_b, bubble_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  hazard_forward_unit #(.NUM_SRC(2), .AW(5), .LOAD_STALL(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen), .ex_is_load(ex_is_load),
    .flush(flush), .clr_cnt(clr_cnt), .fwd_sel(fwd_a), .stall(stall_a),
    .bubble(bubble_a), .stall_cnt(cnt_a)
  );

  hazard_forward_unit #(.NUM_SRC(2), .AW(5), .LOAD_STALL(3), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
    .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen), .ex_is_load(ex_is_load),
    .flush(flush), .clr_cnt(clr_cnt), .fwd_sel(fwd_b), .stall(stall_b),
    .bubble(bubble_b), .stall_cnt(cnt_b)
  );

  typedef struct {
    string       tag;
    logic [3:0]  fwd;
    logic        stall_a;
    logic        stall_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Model state: stall cycles still owed after the current one, and the counters.
  int left_a = 0, left_b = 0;
  int mcnt_a = 0, mcnt_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input int i);
    logic [4:0] s;
    s = id_src[i*5 +: 5];
    if (!id_src_used[i]) return 2'd0;
    if (ex_wen  && ex_dst  != 0 && ex_dst  == s) return 2'd3;
    if (mem_wen && mem_dst != 0 && mem_dst == s) return 2'd2;
    if (wb_wen  && wb_dst  != 0 && wb_dst  == s) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit hazard_now();
    bit hit = 0;
    for (int i = 0; i < 2; i++)
      if (id_src_used[i] && ex_wen && ex_dst != 0 && ex_dst == id_src[i*5 +: 5]) hit = 1;
    return id_valid && !flush && ex_is_load && hit;
  endfunction

  function automatic bit exp_stall(input int left);
    if (!rst_n) return 1'b0;
    if (left > 0) return !flush;
    return hazard_now();
  endfunction

  // One clock cycle: expectations for the current inputs, then model advance at the edge.
  task automatic step(input string tag);
    exp_t e;
    bit   h;
    if (!rst_n) begin
      left_a = 0; left_b = 0; mcnt_a = 0; mcnt_b = 0;
    end
    e.tag     = tag;
    e.fwd     = rst_n ? {exp_fwd(1), exp_fwd(0)} : 4'd0;
    e.stall_a = exp_stall(left_a);
    e.stall_b = exp_stall(left_b);
    e.cnt_a   = 16'(mcnt_a);
    e.cnt_b   = 4'(mcnt_b);
    exp_q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      h = hazard_now();
      mcnt_a = clr_cnt ? 0 : ((e.stall_a && mcnt_a < 65535) ? mcnt_a + 1 : mcnt_a);
      mcnt_b = clr_cnt ? 0 : ((e.stall_b && mcnt_b < 15) ? mcnt_b + 1 : mcnt_b);
      if (left_a > 0) left_a = flush ? 0 : left_a - 1;
      else if (h)     left_a = 1 - 1;
      if (left_b > 0) left_b = flush ? 0 : left_b - 1;
      else if (h)     left_b = 3 - 1;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    id_valid = 0; ex_wen = 0; mem_wen = 0; wb_wen = 0; ex_is_load = 0;
    flush = 0; clr_cnt = 0; id_src = '0; id_src_used = '0;
    ex_dst = '0; mem_dst = '0; wb_dst = '0;
  endtask

  task automatic load_use();
    id_valid = 1; id_src = {5'd0, 5'd5}; id_src_used = 2'b01;
    ex_is_load = 1; ex_wen = 1; ex_dst = 5'd5;
  endtask

  // Monitor: samples between the driving negedge and the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".fwd_a"},    32'(fwd_a),    32'(e.fwd));
        check({e.tag, ".fwd_b"},    32'(fwd_b),    32'(e.fwd));
        check({e.tag, ".stall_a"},  32'(stall_a),  32'(e.stall_a));
        check({e.tag, ".bubble_a"}, 32'(bubble_a), 32'(e.stall_a));
        check({e.tag, ".stall_b"},  32'(stall_b),  32'(e.stall_b));
        check({e.tag, ".bubble_b"}, 32'(bubble_b), 32'(e.stall_b));
        check({e.tag, ".cnt_a"},    32'(cnt_a),    32'(e.cnt_a));
        check({e.tag, ".cnt_b"},    32'(cnt_b),    32'(e.cnt_b));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    quiet();
    @(negedge clk);
    id_valid = 1; id_src = {5'd3, 5'd3}; id_src_used = 2'b11;
    ex_wen = 1; mem_wen = 1; wb_wen = 1; ex_dst = 3; mem_dst = 3; wb_dst = 3;
    step("reset_forced");
    rst_n = 1;
    quiet();
    step("reset_idle");

    // Forwarding priority
    id_valid = 1; id_src = {5'd3, 5'd3}; id_src_used = 2'b11;
    ex_wen = 1; mem_wen = 1; wb_wen = 1; ex_dst = 3; mem_dst = 3; wb_dst = 3;
    step("prio_ex");
    ex_wen = 0;      step("prio_mem");
    mem_wen = 0;     step("prio_wb");
    wb_dst = 0;      step("prio_wb_r0");
    wb_dst = 3; id_src_used = 2'b10; step("prio_unused");
    id_src = {5'd7, 5'd3}; id_src_used = 2'b11; mem_wen = 1; mem_dst = 7; step("prio_split");

    // Load-use: one stall in config A, three in config B
    quiet(); clr_cnt = 1; step("clr");
    quiet(); load_use(); step("lu_hazard");
    ex_wen = 0; step("lu_hold1");
    step("lu_hold2");
    step("lu_after");
    quiet(); step("lu_counts");
    ex_is_load = 1; ex_wen = 0; ex_dst = 5; id_valid = 1; id_src = {5'd0, 5'd5};
    id_src_used = 2'b01; step("load_no_wen");
    ex_wen = 1; ex_dst = 0; id_src = 10'd0; step("load_r0");

    // Flush during HOLD and flush coincident with a hazard
    quiet(); clr_cnt = 1; step("clr2");
    quiet(); load_use(); step("fl_hazard");
    ex_wen = 0; flush = 1; step("fl_in_hold");
    flush = 0; step("fl_idle");
    load_use(); flush = 1; step("fl_with_hazard");
    quiet(); step("fl_counts");

    // Saturation, clear-over-increment, reset mid-HOLD
    clr_cnt = 1; step("clr3");
    clr_cnt = 0; load_use();
    for (int i = 0; i < 20; i++) step("sat_run");
    quiet(); step("sat_value");
    load_use(); clr_cnt = 1; step("clr_with_stall");
    clr_cnt = 0; ex_wen = 0; step("post_clr");
    quiet(); step("drain");
    load_use(); step("rst_hazard");
    ex_wen = 0; step("rst_hold");
    rst_n = 0; step("rst_mid_hold");
    rst_n = 1; quiet(); step("rst_release");

    // Randomized traffic over a small register window to force frequent matches
    for (int i = 0; i < 800; i++) begin
      rst_n       = ($urandom_range(0, 63) != 0);
      id_valid    = ($urandom_range(0, 7) != 0);
      id_src      = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_src_used = 2'($urandom_range(0, 3));
      ex_dst      = 5'($urandom_range(0, 3));
      mem_dst     = 5'($urandom_range(0, 3));
      wb_dst      = 5'($urandom_range(0, 3));
      ex_wen      = 1'($urandom_range(0, 1));
      mem_wen     = 1'($urandom_range(0, 1));
      wb_wen      = 1'($urandom_range(0, 1));
      ex_is_load  = ($urandom_range(0, 2) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      clr_cnt     = ($urandom_range(0, 31) == 0);
      step("rand");
    end

    quiet();
    step("final");
    #5;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter NUM_SRC, default 2, number of decode-stage source operands; legal range 1..4.
REQ-002 Parameter AW, default 5, register address width.
REQ-003 Parameter LOAD_STALL, default 1, number of stall cycles per load-use hazard; legal range 1..3.
REQ-004 Parameter CNT_W, default 16, width of the stall statistics counter.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 id_valid  in  1  decode stage holds a valid instruction.
REQ-008 id_src  in  NUM_SRC*AW  packed source addresses; source i at bits [i*AW +: AW].
REQ-009 id_src_used  in  NUM_SRC  bit i set = source i is read by the decode instruction.
REQ-010 ex_dst / mem_dst / wb_dst  in  AW each  destination register of the EX, MEM and WB stage instructions.
REQ-011 ex_wen / mem_wen / wb_wen  in  1 each  stage instruction writes its destination.
REQ-012 ex_is_load  in  1  EX stage instruction is a load.
REQ-013 flush  in  1  decode instruction is being squashed this cycle (taken branch/jump).
REQ-014 clr_cnt  in  1  synchronous clear of stall_cnt.
REQ-015 fwd_sel  out  NUM_SRC*2  per-source bypass select; source i at bits [2i +: 2].
REQ-016 stall  out  1  freeze PC and IF/ID register this cycle.
REQ-017 bubble  out  1  insert NOP into ID/EX this cycle.
REQ-018 stall_cnt  out  CNT_W  count of cycles with stall high.

Function
REQ-019 fwd_sel encoding SHALL be: 00 register file, 01 WB stage, 10 MEM stage, 11 EX stage.
REQ-020 A stage matches source i when its wen is 1, its dst is nonzero, and its dst equals source i.
REQ-021 fwd_sel for source i SHALL use priority EX > MEM > WB, and SHALL be 00 when no stage matches or id_src_used[i]=0.
REQ-022 fwd_sel SHALL be combinational, with zero-cycle latency from its inputs, and SHALL NOT depend on the state machine.
REQ-023 hazard SHALL be 1 when id_valid=1, flush=0, ex_is_load=1 and EX matches any used source; ex_is_load with ex_wen=0 or ex_dst=0 SHALL NOT cause a hazard.
REQ-024 The state machine SHALL have two states, IDLE and HOLD, plus a down-counter rem of width 2.
REQ-025 In IDLE, stall=bubble=hazard.
REQ-026 In IDLE, if hazard=1 and LOAD_STALL>1, the next state SHALL be HOLD with rem=LOAD_STALL-1; otherwise the state SHALL remain IDLE.
REQ-027 In HOLD, stall=bubble=1, and rem SHALL decrement each cycle.
REQ-028 In HOLD, when rem=1 the state SHALL return to IDLE the next cycle, so exactly LOAD_STALL consecutive stall cycles occur per hazard.
REQ-029 flush=1 in HOLD SHALL force stall=bubble=0 that cycle and return the state to IDLE next cycle.
REQ-030 flush=1 in IDLE SHALL suppress hazard, and flush SHALL win over a simultaneous hazard.
REQ-031 stall_cnt SHALL increment by 1 on each rising edge where stall=1, saturating at all-ones without wrapping.
REQ-032 clr_cnt=1 SHALL load stall_cnt with 0 at the next edge, with priority over increment.

Reset
REQ-033 rst_n=0 SHALL immediately, without waiting for a clock edge, set state to IDLE, rem to 0 and stall_cnt to 0.
REQ-034 While rst_n=0, the outputs SHALL be forced: stall=0, bubble=0 and fwd_sel all zero.
REQ-035 After rst_n deasserts, the block SHALL operate from the first rising edge, with no dummy cycles.

Verification
REQ-036 Priority test: NUM_SRC=2, id_src={r3,r3}, used=11, ex/mem/wb all wen with dst=3, no load -> fwd_sel=1111; drop ex_wen -> 1010; drop mem_wen -> 0101; set wb_dst=0 -> 0000.
REQ-037 Load-use test: LOAD_STALL=1, ex_is_load, ex_dst=r5, id_src0=r5 used -> stall=bubble=1 for exactly 1 cycle, stall_cnt=1.
REQ-038 Long-stall test: repeat REQ-037 with LOAD_STALL=3, holding ex_wen=0 after the first cycle -> stall high for 3 consecutive cycles, then 0; stall_cnt=3.
REQ-039 Flush test: LOAD_STALL=3; assert flush in the 2nd stall cycle -> stall=0 that cycle, IDLE next cycle, stall_cnt=1; flush coincident with hazard -> no stall.
REQ-040 Saturation and reset test: CNT_W=4 with 20 stall cycles -> stall_cnt=15; clr_cnt together with stall -> 0; rst_n low mid-HOLD -> stall=0 immediately and stall_cnt=0.
